// File: rtl/tap_interval_meter_if.sv
// Button/measurement bundle for tap_interval_meter.
//   btn            : raw, asynchronous, bouncing button level (1 = pressed)
//   interval_ms    : last accepted tap interval in milliseconds
//   interval_valid : one-cycle strobe when interval_ms updates
//   timeout        : one-cycle strobe when a pending measurement is abandoned
//   busy           : a first tap is pending (TIMING state)
// master drives the button and observes results; slave is the meter itself.
interface tap_interval_meter_if;
  logic        btn;
  logic [15:0] interval_ms;
  logic        interval_valid;
  logic        timeout;
  logic        busy;

  modport master (
    output btn,
    input  interval_ms,
    input  interval_valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  btn,
    output interval_ms,
    output interval_valid,
    output timeout,
    output busy
  );
endinterface

// File: rtl/tap_interval_meter.sv
// Tap-tempo meter: synchronises and debounces a push-button, then measures the
// whole milliseconds between successive debounced presses. Each press after the
// first closes one interval (interval_valid strobe) and opens the next. If no
// press arrives within TIMEOUT_MS the pending measurement is dropped (timeout
// strobe) and the block returns to idle.
// Ports:
//   clk    : system clock
//   rst    : asynchronous, active-high reset
//   tap_io : slave side of tap_interval_meter_if (btn in; interval_ms,
//            interval_valid, timeout, busy out; all outputs registered)
module tap_interval_meter #(
  parameter int unsigned CYCLES_PER_MS   = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned TIMEOUT_MS      = 4000
) (
  input  logic                  clk,
  input  logic                  rst,
  tap_interval_meter_if.slave   tap_io
);

  localparam int unsigned PsW = $clog2(CYCLES_PER_MS);
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PsW-1:0] PsLast  = PsW'(CYCLES_PER_MS - 1);
  localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]    MsLimit = 16'(TIMEOUT_MS);

  typedef enum logic [0:0] {StIdle, StTiming} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [PsW-1:0]   presc_q, presc_d;
  logic [15:0]      ms_q, ms_d;
  logic [15:0]      interval_q, interval_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             press;
  logic             tick;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DbLast) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press = db_q & ~db_dly_q;
  assign tick  = (state_q == StTiming) && (presc_q == PsLast);

  // The press cycle itself counts as prescaler count 0, so the next cycle
  // loads 1. This makes the result exactly floor(tap spacing / CYCLES_PER_MS)
  // even though a tick coinciding with a press is discarded.
  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    ms_d       = ms_q;
    interval_d = interval_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ms_d = '0;
        if (press) begin
          state_d = StTiming;
          presc_d = PsW'(1);
        end
      end
      StTiming: begin
        if (press) begin
          presc_d    = PsW'(1);
          ms_d       = '0;
          valid_d    = 1'b1;
          interval_d = (ms_q == 16'd0) ? 16'd1 : ms_q;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (ms_q == MsLimit) begin
              state_d   = StIdle;
              ms_d      = '0;
              timeout_d = 1'b1;
            end else begin
              ms_d = ms_q + 16'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      db_dly_q   <= 1'b0;
      db_cnt_q   <= '0;
      presc_q    <= '0;
      ms_q       <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= tap_io.btn;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_dly_q   <= db_q;
      db_cnt_q   <= db_cnt_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tap_io.interval_ms    = interval_q;
  assign tap_io.interval_valid = valid_q;
  assign tap_io.timeout        = timeout_q;
  assign tap_io.busy           = (state_q == StTiming);

endmodule
